jk_latch_driver: RTL and testbench
==================================

Name: jk_latch_driver

Overview:
- Drives the J, K and E inputs of a W-bit bank of level-sensitive JK latches from a valid/ready command port.
- Keeps a shadow copy of the latch bank state and uses the JK excitation table to turn each command into per-bit J/K values.
- Sequences E as a setup/pulse/hold waveform, then reads the latch Q outputs back and reports any mismatch.
- Sits between a register-file or control FSM and the latch bank.

Parameters:
- W, 8, width of the latch bank and command data.
- SETUP_CYC, 1, cycles J/K are held stable with E=0 before the enable pulse (minimum 1).
- PULSE_CYC, 1, cycles E=1 (minimum 1). Must stay short so that a toggle operation does not oscillate.
- HOLD_CYC, 1, cycles J/K are held after E falls (minimum 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  block can accept a command.
- req_mode  in  2  00=write target, 01=toggle mask, 10=clear all, 11=set all.
- req_data  in  W  target word (mode 00) or toggle mask (mode 01); ignored in modes 10/11.
- j  out  W  J drive to the latch bank.
- k  out  W  K drive to the latch bank.
- e  out  1  enable drive to the latch bank.
- q_rb  in  W  latch Q readback, synchronised externally.
- shadow_q  out  W  modelled latch state.
- done  out  1  one-cycle pulse when a command completes.
- mismatch  out  1  sticky flag: readback differed from the shadow; cleared by the next accepted command.

Behaviour:
- Reset (async, rst_n=0) forces:
  - j=0, k=0, e=0, done=0, mismatch=0;
  - shadow_q=0, req_ready=1;
  - FSM to IDLE and all counters to 0.
- Reset mid-operation aborts immediately: e drops to 0 asynchronously.
- FSM states are IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - req_ready=1.
  - A handshake occurs on req_valid && req_ready at a clock edge.
  - On handshake: register j/k per the mode, load the next-shadow value, clear mismatch, go to SETUP.
  - req_ready=0 in every state other than IDLE. No command queue.
- J/K generation per bit, with s = current shadow_q and t = target:
  - Mode 00:
    - s=0, t=1: J=1, K=0.
    - s=1, t=0: J=0, K=1.
    - s=t: J=0, K=0.
    - Next shadow = req_data.
  - Mode 01, mask bit = 1: J=1, K=1 (toggle), next shadow = ~s.
  - Mode 01, mask bit = 0: J=0, K=0, shadow bit unchanged.
  - Mode 10: J=0, K=1 for all bits; next shadow = 0.
  - Mode 11: J=1, K=0 for all bits; next shadow = all ones.
- SETUP: e=0 for SETUP_CYC cycles, then go to PULSE.
- PULSE: e=1 for exactly PULSE_CYC cycles, then go to HOLD.
- HOLD:
  - e=0 and j/k keep their values for HOLD_CYC cycles.
  - At the end of HOLD: shadow_q takes the next-shadow value, then go to CHECK.
- CHECK (1 cycle):
  - Compare q_rb against shadow_q; set mismatch if they differ.
  - Zero j/k, pulse done=1, return to IDLE.
  - req_ready rises on the cycle after done. This gives a minimum command spacing of SETUP+PULSE+HOLD+2 cycles.
- Boundary conditions:
  - A command that changes no bits (mode 00 with req_data == shadow_q) still runs the full sequence with J=K=0.
  - Mode 01 with an all-zero mask likewise runs the full sequence with no bit changes.
  - A mismatch does not alter shadow_q: shadow_q always holds the commanded value, and software re-issues the command.
  - req_valid asserted while busy is ignored, i.e. not accepted; the requester must hold it until req_ready.
- Outputs are registered and glitch-free: e is a flop output and j/k never change while e=1.

Decomposition:
- Shared package jk_pkg:
  - mode constants JK_WRITE=2'b00, JK_TOGGLE=2'b01, JK_CLEAR=2'b10, JK_SET=2'b11;
  - FSM state encoding.
- One natural sub-module, jk_excite: a purely combinational per-word excitation encoder.
  - Inputs: mode, data, shadow.
  - Outputs: j, k, next_shadow.
  - Reused by the verification model.

Test Plan:
- Reset, then write 8'hA5 with q_rb following the ideal latch:
  - j=A5, k=00; e high exactly 1 cycle, at cycle 2 after accept;
  - done at cycle 4 after accept; shadow_q=A5, mismatch=0.
- From A5, write 8'h3C:
  - j=18, k=81, shadow_q=3C.
- From 3C, toggle mask 8'h0F:
  - j=0F, k=0F, shadow_q=33.
- Clear all, then set all:
  - clear gives j=00, k=FF, shadow=00;
  - set gives j=FF, k=00, shadow=FF.
- Write 8'h01 with q_rb stuck at 00:
  - mismatch=1 after done, shadow_q=01;
  - mismatch cleared to 0 by the next accepted command.
- Assert rst_n=0 during PULSE:
  - e=0 immediately, shadow_q=00, req_ready=1;
  - req_valid held during the busy states is not accepted until IDLE.

Source files
------------

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared mode constants, FSM encoding and sizing helper for the JK latch driver
//
// Purpose : command-mode encodings, sequencer state type and a counter
//           width helper used by jk_excite and jk_latch_driver.
// Contents: JK_WRITE/JK_TOGGLE/JK_CLEAR/JK_SET, jk_state_e, jk_cnt_width().

package jk_pkg;

  localparam logic [1:0] JK_WRITE  = 2'b00;
  localparam logic [1:0] JK_TOGGLE = 2'b01;
  localparam logic [1:0] JK_CLEAR  = 2'b10;
  localparam logic [1:0] JK_SET    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } jk_state_e;

  // The phase counter only ever holds 0 .. max_cyc-1.
  function automatic int jk_cnt_width(input int max_cyc);
    if (max_cyc <= 2) begin
      return 1;
    end
    return $clog2(max_cyc);
  endfunction

endpackage

// File: rtl/jk_excite.sv
// rtl/jk_excite.sv - combinational JK excitation encoder for one W-bit word
//
// Purpose : turns a command (mode, data) and the current latch state into
//           per-bit J/K drive and the state the latches will hold afterwards.
// Ports   : mode_i        command mode (jk_pkg JK_* constants)
//           data_i        target word (write) or toggle mask (toggle)
//           shadow_i      current modelled latch state
//           j_o, k_o      J/K drive values
//           next_shadow_o latch state after the enable pulse

module jk_excite
  import jk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   mode_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] shadow_i,
  output logic [W-1:0] j_o,
  output logic [W-1:0] k_o,
  output logic [W-1:0] next_shadow_o
);

  always_comb begin
    j_o           = '0;
    k_o           = '0;
    next_shadow_o = shadow_i;
    case (mode_i)
      JK_WRITE: begin
        // Set only the bits that must rise, reset only those that must fall;
        // unchanged bits get J=K=0 so they hold.
        j_o           = ~shadow_i & data_i;
        k_o           = shadow_i & ~data_i;
        next_shadow_o = data_i;
      end
      JK_TOGGLE: begin
        j_o           = data_i;
        k_o           = data_i;
        next_shadow_o = shadow_i ^ data_i;
      end
      JK_CLEAR: begin
        j_o           = '0;
        k_o           = '1;
        next_shadow_o = '0;
      end
      JK_SET: begin
        j_o           = '1;
        k_o           = '0;
        next_shadow_o = '1;
      end
      default: begin
        j_o           = '0;
        k_o           = '0;
        next_shadow_o = shadow_i;
      end
    endcase
  end

endmodule

// File: rtl/jk_latch_driver.sv
// rtl/jk_latch_driver.sv - valid/ready sequencer driving J/K/E of a level-sensitive JK latch bank
//
// Purpose : accepts one command at a time, drives J/K for the whole
//           setup/pulse/hold window, pulses E, updates a shadow copy of the
//           latch state and compares it with the latch readback.
// Ports   : clk, rst_n            clock, async active-low reset
//           req_valid/req_ready   command handshake
//           req_mode, req_data    command mode and operand
//           j, k, e               latch bank drive (all flop outputs)
//           q_rb                  synchronised latch Q readback
//           shadow_q              modelled latch state
//           done                  one-cycle completion pulse
//           mismatch              sticky readback-mismatch flag

module jk_latch_driver
  import jk_pkg::*;
#(
  parameter int W         = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_mode,
  input  logic [W-1:0] req_data,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         e,
  input  logic [W-1:0] q_rb,
  output logic [W-1:0] shadow_q,
  output logic         done,
  output logic         mismatch
);

  localparam int MAX_CYC_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC   = (MAX_CYC_A > HOLD_CYC) ? MAX_CYC_A : HOLD_CYC;
  localparam int CW        = jk_cnt_width(MAX_CYC);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  jk_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   j_q, j_d;
  logic [W-1:0]   k_q, k_d;
  logic [W-1:0]   shadow_d;
  logic [W-1:0]   next_shadow_q, next_shadow_d;
  logic           e_q, e_d;
  logic           done_q, done_d;
  logic           mismatch_q, mismatch_d;
  logic           ready_q, ready_d;

  logic [W-1:0]   exc_j;
  logic [W-1:0]   exc_k;
  logic [W-1:0]   exc_next;

  jk_excite #(.W(W)) u_excite (
    .mode_i        (req_mode),
    .data_i        (req_data),
    .shadow_i      (shadow_q),
    .j_o           (exc_j),
    .k_o           (exc_k),
    .next_shadow_o (exc_next)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    j_d           = j_q;
    k_d           = k_q;
    shadow_d      = shadow_q;
    next_shadow_d = next_shadow_q;
    mismatch_d    = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          j_d           = exc_j;
          k_d           = exc_k;
          next_shadow_d = exc_next;
          mismatch_d    = 1'b0;
          cnt_d         = '0;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          // Shadow follows the command, not the readback.
          cnt_d    = '0;
          shadow_d = next_shadow_q;
          state_d  = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        if (q_rb != shadow_q) begin
          mismatch_d = 1'b1;
        end
        j_d     = '0;
        k_d     = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flop outputs are decoded from the next state so they line up with it.
    e_d     = (state_d == ST_PULSE);
    done_d  = (state_d == ST_CHECK);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      j_q           <= '0;
      k_q           <= '0;
      shadow_q      <= '0;
      next_shadow_q <= '0;
      e_q           <= 1'b0;
      done_q        <= 1'b0;
      mismatch_q    <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      j_q           <= j_d;
      k_q           <= k_d;
      shadow_q      <= shadow_d;
      next_shadow_q <= next_shadow_d;
      e_q           <= e_d;
      done_q        <= done_d;
      mismatch_q    <= mismatch_d;
      ready_q       <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign e         = e_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// tb/tb_jk_latch_driver.sv - directed self-checking bench for jk_latch_driver

module tb_jk_latch_driver;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_mode;
  logic [7:0] req_data;
  logic [7:0] j;
  logic [7:0] k;
  logic       e;
  logic [7:0] q_rb;
  logic [7:0] shadow_q;
  logic       done;
  logic       mismatch;

  logic [7:0] latch;
  logic       stuck;

  int n_checks;
  int n_errors;

  jk_latch_driver #(.W(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .j         (j),
    .k         (k),
    .e         (e),
    .q_rb      (q_rb),
    .shadow_q  (shadow_q),
    .done      (done),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal JK latch bank: transparent while e=1, evaluated once per cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch <= 8'h00;
    end else if (e) begin
      for (int b = 0; b < 8; b++) begin
        case ({j[b], k[b]})
          2'b10:   latch[b] <= 1'b1;
          2'b01:   latch[b] <= 1'b0;
          2'b11:   latch[b] <= ~latch[b];
          default: latch[b] <= latch[b];
        endcase
      end
    end
  end

  assign q_rb = stuck ? 8'h00 : latch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Observe cycles 1..5 after the accepting edge.
  task automatic observe(input string tag, input logic [7:0] exp_j, input logic [7:0] exp_k,
                         input logic [7:0] exp_sh, input logic exp_mm);
    int e_cnt, e_at, d_cnt, d_at;
    e_cnt = 0; e_at = 0; d_cnt = 0; d_at = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "_j"}, 32'(j), 32'(exp_j));
        chk({tag, "_k"}, 32'(k), 32'(exp_k));
        chk({tag, "_mm_clr"}, 32'(mismatch), 32'd0);
        chk({tag, "_busy"}, 32'(req_ready), 32'd0);
      end
      if (c == 4) chk({tag, "_ready_c4"}, 32'(req_ready), 32'd0);
      if (e) begin e_cnt++; e_at = c; end
      if (done) begin d_cnt++; d_at = c; end
    end
    chk({tag, "_e_cnt"}, 32'(e_cnt), 32'd1);
    chk({tag, "_e_at"}, 32'(e_at), 32'd2);
    chk({tag, "_done_cnt"}, 32'(d_cnt), 32'd1);
    chk({tag, "_done_at"}, 32'(d_at), 32'd4);
    chk({tag, "_shadow"}, 32'(shadow_q), 32'(exp_sh));
    chk({tag, "_mismatch"}, 32'(mismatch), 32'(exp_mm));
    chk({tag, "_ready_c5"}, 32'(req_ready), 32'd1);
    chk({tag, "_jk_zero"}, 32'({j, k}), 32'd0);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] m, input logic [7:0] d,
                        input logic [7:0] exp_j, input logic [7:0] exp_k,
                        input logic [7:0] exp_sh, input logic exp_mm);
    wait_ready();
    req_valid = 1'b1;
    req_mode  = m;
    req_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 8'hxx;
    observe(tag, exp_j, exp_k, exp_sh, exp_mm);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    stuck     = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 2'b00;
    req_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_e", 32'(e), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_shadow", 32'(shadow_q), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    do_cmd("wr_a5",   2'b00, 8'hA5, 8'hA5, 8'h00, 8'hA5, 1'b0);
    do_cmd("wr_3c",   2'b00, 8'h3C, 8'h18, 8'h81, 8'h3C, 1'b0);
    do_cmd("tg_0f",   2'b01, 8'h0F, 8'h0F, 8'h0F, 8'h33, 1'b0);
    do_cmd("clr",     2'b10, 8'h5A, 8'h00, 8'hFF, 8'h00, 1'b0);
    do_cmd("set",     2'b11, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0);
    do_cmd("wr_same", 2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0);
    do_cmd("tg_zero", 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);

    stuck = 1'b1;
    do_cmd("wr_stuck", 2'b00, 8'h01, 8'h00, 8'hFE, 8'h01, 1'b1);
    stuck = 1'b0;
    do_cmd("wr_recov", 2'b00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);

    // Reset during PULSE with req_valid held through the busy states.
    wait_ready();
    req_valid = 1'b1;
    req_mode  = 2'b00;
    req_data  = 8'h80;
    @(posedge clk);
    @(negedge clk);
    chk("hold_busy_c1", 32'(req_ready), 32'd0);
    chk("hold_e_c1", 32'(e), 32'd0);
    @(negedge clk);
    chk("hold_e_c2", 32'(e), 32'd1);
    chk("hold_busy_c2", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_e", 32'(e), 32'd0);
    chk("arst_shadow", 32'(shadow_q), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_jk", 32'({j, k}), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    observe("post_rst", 8'h80, 8'h00, 8'h80, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
